// File: rtl/axi4lite_reg_bank_if.sv
// AXI4-Lite bus bundle for the register bank.
// Signal names follow the AXI channel names so that an instance called
// S_AXI reads as S_AXI.AWADDR, S_AXI.BVALID and so on.
interface axi4lite_reg_bank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport slave (
        input  AWADDR, AWPROT, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARPROT, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RVALID,
        input  RREADY
    );

    modport master (
        output AWADDR, AWPROT, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARPROT, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RVALID,
        output RREADY
    );
endinterface

// File: rtl/axi4lite_reg_bank.sv
// Parametrised AXI4-Lite register bank feeding the MAC core control fields.
// AW and W are captured independently into skid holds; the write commits
// once both are present. Reads run on their own FSM, fully concurrent.
// Optional feature: define AXI_REGS_ERR_RESP_EN to answer out-of-range
// accesses with SLVERR instead of OKAY.
module axi4lite_reg_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    axi4lite_reg_bank_if.slave             S_AXI,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - OFFS;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t              w_state;
    r_state_t              r_state;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  aw_held;
    logic                  w_held;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    logic [NUM_REGS-1:0]   wr_hit;
    logic [NUM_REGS-1:0]   rd_hit;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            wr_resp;
    logic [1:0]            rd_resp;
    logic [IDX_W-1:0]      rd_idx;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{S_AXI.AWPROT, S_AXI.ARPROT,
                           S_AXI.AWADDR[OFFS-1:0], S_AXI.ARADDR[OFFS-1:0]};

    assign rd_idx = S_AXI.ARADDR[ADDR_WIDTH-1:OFFS];

    // Decode held write index and live read index; no hit means out of range.
    always_comb begin
        wr_hit  = '0;
        rd_hit  = '0;
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (aw_idx_q == IDX_W'(k)) wr_hit[k] = 1'b1;
            if (rd_idx == IDX_W'(k)) begin
                rd_hit[k] = 1'b1;
                rd_data   = regs[k];
            end
        end
    end

`ifdef AXI_REGS_ERR_RESP_EN
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    assign wr_resp = (|wr_hit) ? RESP_OKAY : RESP_SLVERR;
    assign rd_resp = (|rd_hit) ? RESP_OKAY : RESP_SLVERR;
`else
    assign wr_resp = 2'b00;
    assign rd_resp = 2'b00;
`endif

    // Flatten the register array onto the core-facing bus.
    always_comb begin
        reg_out = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            reg_out[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
        end
    end

    // Write FSM: skid-capture AW and W, commit strobed bytes, then hold B until taken.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state       <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx_q      <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            S_AXI.AWREADY <= 1'b1;
            S_AXI.WREADY  <= 1'b1;
            S_AXI.BVALID  <= 1'b0;
            S_AXI.BRESP   <= 2'b00;
            wr_pulse      <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            wr_pulse <= '0;
            case (w_state)
                W_IDLE: begin
                    if (aw_held && w_held) begin
                        for (int k = 0; k < NUM_REGS; k++) begin
                            for (int b = 0; b < STRB_W; b++) begin
                                if (wr_hit[k] && w_strb_q[b]) regs[k][b*8 +: 8] <= w_data_q[b*8 +: 8];
                            end
                        end
                        wr_pulse     <= wr_hit & {NUM_REGS{|w_strb_q}};
                        S_AXI.BVALID <= 1'b1;
                        S_AXI.BRESP  <= wr_resp;
                        aw_held      <= 1'b0;
                        w_held       <= 1'b0;
                        w_state      <= W_RESP;
                    end else begin
                        if (S_AXI.AWVALID && S_AXI.AWREADY) begin
                            aw_held       <= 1'b1;
                            aw_idx_q      <= S_AXI.AWADDR[ADDR_WIDTH-1:OFFS];
                            S_AXI.AWREADY <= 1'b0;
                        end
                        if (S_AXI.WVALID && S_AXI.WREADY) begin
                            w_held       <= 1'b1;
                            w_data_q     <= S_AXI.WDATA;
                            w_strb_q     <= S_AXI.WSTRB;
                            S_AXI.WREADY <= 1'b0;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI.BREADY) begin
                        S_AXI.BVALID  <= 1'b0;
                        S_AXI.AWREADY <= 1'b1;
                        S_AXI.WREADY  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: register data on AR handshake and hold it until RREADY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state       <= R_IDLE;
            S_AXI.ARREADY <= 1'b1;
            S_AXI.RVALID  <= 1'b0;
            S_AXI.RDATA   <= '0;
            S_AXI.RRESP   <= 2'b00;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (S_AXI.ARVALID) begin
                        S_AXI.RDATA   <= rd_data;
                        S_AXI.RRESP   <= rd_resp;
                        S_AXI.RVALID  <= 1'b1;
                        S_AXI.ARREADY <= 1'b0;
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI.RREADY) begin
                        S_AXI.RVALID  <= 1'b0;
                        S_AXI.ARREADY <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_reg_bank.sv
// Self-checking bench for axi4lite_reg_bank (default parameters).
// Response expectations for out-of-range accesses follow AXI_REGS_ERR_RESP_EN.
module tb_axi4lite_reg_bank;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AW = 8;

`ifdef AXI_REGS_ERR_RESP_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    strb;
        logic [DW-1:0] exp_reg;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rd_exp_t;

    logic ACLK = 1'b0;
    logic ARESET = 1'b0;
    logic [NR*DW-1:0] reg_out;
    logic [NR-1:0]    wr_pulse;

    logic [1:0]    b_q[$];
    rd_exp_t       r_q[$];
    logic [DW-1:0] model [NR];
    vec_t          vecs [9];

    int checks = 0;
    int passes = 0;

    axi4lite_reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4lite_reg_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .S_AXI    (bus),
        .reg_out  (reg_out),
        .wr_pulse (wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] reg_slice(input int k);
        return reg_out[k*DW +: DW];
    endfunction

    task automatic check_model();
        for (int k = 0; k < NR; k++) check_output($sformatf("reg%0d vs model", k), reg_slice(k), model[k]);
    endtask

    // Scoreboard: compare B and R beats against queued expectations.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (bus.BVALID && bus.BREADY) begin
                check_output("B beat expected", DW'(b_q.size() > 0), 1);
                if (b_q.size() > 0) check_output("BRESP", DW'(bus.BRESP), DW'(b_q.pop_front()));
            end
            if (bus.RVALID && bus.RREADY) begin
                check_output("R beat expected", DW'(r_q.size() > 0), 1);
                if (r_q.size() > 0) begin
                    rd_exp_t e;
                    e = r_q.pop_front();
                    check_output("RDATA", bus.RDATA, e.data);
                    check_output("RRESP", DW'(bus.RRESP), DW'(e.resp));
                end
            end
        end
    end

    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb);
        int idx;
        int n;
        logic aw_pend, w_pend, aw_hs, w_hs;
        logic [NR-1:0] exp_pulse;
        idx = int'(addr >> 2);
        exp_pulse = '0;
        if (idx < NR) begin
            if (strb != 4'b0) exp_pulse[idx] = 1'b1;
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        @(posedge ACLK); #1;
        bus.AWADDR = addr; bus.AWVALID = 1'b1;
        bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1;
        bus.BREADY = 1'b1;
        b_q.push_back((idx < NR) ? 2'b00 : OOR_RESP);
        aw_pend = 1'b1; w_pend = 1'b1; n = 0;
        while ((aw_pend || w_pend) && n < 20) begin
            @(negedge ACLK);
            aw_hs = aw_pend && bus.AWREADY;
            w_hs  = w_pend && bus.WREADY;
            @(posedge ACLK); #1;
            if (aw_hs) begin bus.AWVALID = 1'b0; aw_pend = 1'b0; end
            if (w_hs) begin bus.WVALID = 1'b0; w_pend = 1'b0; end
            n++;
        end
        check_output("AW/W accepted", DW'(aw_pend || w_pend), 0);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        n = 0;
        @(negedge ACLK);
        while (!bus.BVALID && n < 20) begin @(negedge ACLK); n++; end
        check_output("BVALID seen", DW'(bus.BVALID), 1);
        check_output($sformatf("wr_pulse @0x%0h", addr), DW'(wr_pulse), DW'(exp_pulse));
        @(negedge ACLK);
        check_output("wr_pulse one cycle", DW'(wr_pulse), 0);
        check_output("BVALID dropped", DW'(bus.BVALID), 0);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data);
        int n;
        rd_exp_t e;
        e.data = exp_data;
        e.resp = (int'(addr >> 2) < NR) ? 2'b00 : OOR_RESP;
        @(posedge ACLK); #1;
        bus.ARADDR = addr; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
        r_q.push_back(e);
        n = 0;
        @(negedge ACLK);
        while (!bus.ARREADY && n < 20) begin @(negedge ACLK); n++; end
        check_output("ARREADY seen", DW'(bus.ARREADY), 1);
        @(posedge ACLK); #1;
        bus.ARVALID = 1'b0;
        n = 0;
        @(negedge ACLK);
        while (!bus.RVALID && n < 20) begin @(negedge ACLK); n++; end
        check_output("RVALID seen", DW'(bus.RVALID), 1);
        @(posedge ACLK); #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        axi_write(v.addr, v.data, v.strb);
        check_output($sformatf("reg @0x%0h", v.addr), reg_slice(int'(v.addr >> 2)), v.exp_reg);
        axi_read(v.addr, v.exp_reg);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic ok;
        int bv_cnt, pulse_cnt, p2_cnt;

        vecs[0] = '{8'h00, 32'h0000_0001, 4'hF, 32'h0000_0001};
        vecs[1] = '{8'h04, 32'h0000_0002, 4'hF, 32'h0000_0002};
        vecs[2] = '{8'h08, 32'h0000_0003, 4'hF, 32'h0000_0003};
        vecs[3] = '{8'h0C, 32'h0000_0004, 4'hF, 32'h0000_0004};
        vecs[4] = '{8'h04, 32'h1122_3344, 4'hF, 32'h1122_3344};
        vecs[5] = '{8'h04, 32'hFFFF_FFFF, 4'h5, 32'h11FF_33FF};
        vecs[6] = '{8'h04, 32'h0000_DEAD, 4'h0, 32'h11FF_33FF};
        vecs[7] = '{8'h07, 32'h0000_0055, 4'hF, 32'h0000_0055};
        vecs[8] = '{8'h3C, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D};

        for (int k = 0; k < NR; k++) model[k] = '0;
        bus.AWADDR = '0; bus.AWPROT = 3'b0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARPROT = 3'b0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

        // Reset state
        #1 ARESET = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        check_output("reset AWREADY", DW'(bus.AWREADY), 1);
        check_output("reset WREADY", DW'(bus.WREADY), 1);
        check_output("reset ARREADY", DW'(bus.ARREADY), 1);
        check_output("reset BVALID", DW'(bus.BVALID), 0);
        check_output("reset RVALID", DW'(bus.RVALID), 0);
        check_output("reset RDATA", bus.RDATA, 0);
        check_output("reset wr_pulse", DW'(wr_pulse), 0);
        check_output("reset reg_out", DW'(|reg_out), 0);
        @(negedge ACLK);
        ARESET = 1'b0;

        // Table-driven write/read-back vectors
        for (int i = 0; i < 9; i++) apply_stimulus(vecs[i]);
        check_model();

        // W arrives three cycles before AW
        @(posedge ACLK); #1;
        bus.WDATA = 32'hAABB_CCDD; bus.WSTRB = 4'hF; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
        b_q.push_back(2'b00);
        @(posedge ACLK); #1;
        bus.WVALID = 1'b0;
        @(negedge ACLK);
        check_output("WREADY low while W held", DW'(bus.WREADY), 0);
        check_output("AWREADY high while only W held", DW'(bus.AWREADY), 1);
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        bus.AWADDR = 8'h08; bus.AWVALID = 1'b1;
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0;
        bv_cnt = 0; pulse_cnt = 0; p2_cnt = 0;
        repeat (8) begin
            @(negedge ACLK);
            bv_cnt += int'(bus.BVALID);
            pulse_cnt += $countones(wr_pulse);
            p2_cnt += int'(wr_pulse[2]);
        end
        model[2] = 32'hAABB_CCDD;
        check_output("split W/AW BVALID cycles", DW'(bv_cnt), 1);
        check_output("split W/AW wr_pulse[2] cycles", DW'(p2_cnt), 1);
        check_output("split W/AW total pulses", DW'(pulse_cnt), 1);
        check_output("split W/AW reg2", reg_slice(2), 32'hAABB_CCDD);

        // BREADY held low: B stable, readies low, two-cycle latency
        @(posedge ACLK); #1;
        bus.AWADDR = 8'h0C; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h0000_0077; bus.WSTRB = 4'hF; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
        b_q.push_back(2'b00);
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        @(negedge ACLK);
        check_output("BVALID not yet", DW'(bus.BVALID), 0);
        @(negedge ACLK);
        check_output("BVALID after two cycles", DW'(bus.BVALID), 1);
        ok = 1'b1;
        repeat (10) begin
            @(negedge ACLK);
            ok &= bus.BVALID && (bus.BRESP == 2'b00) && !bus.AWREADY && !bus.WREADY;
        end
        check_output("B stable under backpressure", DW'(ok), 1);
        @(posedge ACLK); #1;
        bus.BREADY = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        check_output("AWREADY back after B", DW'(bus.AWREADY), 1);
        check_output("WREADY back after B", DW'(bus.WREADY), 1);
        model[3] = 32'h0000_0077;
        check_output("reg3 after stalled B", reg_slice(3), 32'h0000_0077);

        // Out-of-range write and read
        axi_write(8'h40, 32'h1234_5678, 4'hF);
        axi_read(8'h40, 32'h0);
        check_model();

        // Reset while BVALID pending
        @(posedge ACLK); #1;
        bus.AWADDR = 8'h00; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h0000_ABCD; bus.WSTRB = 4'hF; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
        b_q.push_back(2'b00);
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        check_output("BVALID before reset", DW'(bus.BVALID), 1);
        #2 ARESET = 1'b1;
        #1;
        check_output("BVALID cleared by reset", DW'(bus.BVALID), 0);
        check_output("regs cleared by reset", DW'(|reg_out), 0);
        check_output("AWREADY after reset", DW'(bus.AWREADY), 1);
        b_q.delete();
        r_q.delete();
        for (int k = 0; k < NR; k++) model[k] = '0;
        bus.BREADY = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        axi_write(8'h04, 32'h0000_0009, 4'hF);
        axi_read(8'h04, 32'h0000_0009);

        // AR on the same edge as a write commit to the same register
        axi_write(8'h08, 32'h0000_0005, 4'hF);
        @(posedge ACLK); #1;
        bus.AWADDR = 8'h08; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h0000_0009; bus.WSTRB = 4'hF; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
        b_q.push_back(2'b00);
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        bus.ARADDR = 8'h08; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
        r_q.push_back('{data: 32'h0000_0005, resp: 2'b00});
        @(posedge ACLK); #1;
        bus.ARVALID = 1'b0;
        model[2] = 32'h0000_0009;
        repeat (3) @(negedge ACLK);
        axi_read(8'h08, 32'h0000_0009);
        check_model();

        repeat (3) @(posedge ACLK);
        check_output("B queue drained", DW'(b_q.size()), 0);
        check_output("R queue drained", DW'(r_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
